// File: rtl/morse_symbol_capture.sv
// Morse keyer front end: synchronises and debounces the dot/dash buttons,
// collects elements into a word and hands the word downstream over valid/ready.
// Optional ASCII letter decode of the held word: define MORSE_LETTER_DECODE_EN.
module morse_symbol_capture #(
    parameter int unsigned MAX_SYMS     = 4,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned GAP_CYC      = 9000000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            button1,
    input  logic                            button2,
    output logic [MAX_SYMS-1:0]             sym_bits,
    output logic [$clog2(MAX_SYMS+1)-1:0]   sym_len,
    output logic                            sym_valid,
    input  logic                            sym_ready,
    output logic                            overflow,
    output logic                            busy,
    output logic [7:0]                      letter
);

    localparam int unsigned LEN_W = $clog2(MAX_SYMS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    // Index 0 is the dot key, index 1 the dash key; all levels active-low.
    logic [1:0]       raw_c;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [1:0]       ev;
    logic [CNT_W-1:0] dcnt [2];

    assign raw_c = {button2, button1};

    // Two-flop synchroniser, stable-count debouncer and press-event pulse per key.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            ev    <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                ev[i] <= 1'b0;
                if (sync2[i] != db[i]) begin
                    if (dcnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        db[i]   <= sync2[i];
                        dcnt[i] <= '0;
                        ev[i]   <= ~sync2[i];
                    end else begin
                        dcnt[i] <= dcnt[i] + CNT_W'(1);
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    state_t           state;
    state_t           state_n;
    logic [MAX_SYMS-1:0] bits_n;
    logic [LEN_W-1:0] len_n;
    logic             valid_n;
    logic             ovf_n;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_n;
    logic             press_c;
    logic             dash_c;
    logic             both_rel_c;

    // Simultaneous events on both keys cancel each other.
    assign press_c    = ev[0] ^ ev[1];
    assign dash_c     = ev[1];
    assign both_rel_c = &db;

    // Next-state and next-word logic.
    always_comb begin
        state_n = state;
        bits_n  = sym_bits;
        len_n   = sym_len;
        valid_n = sym_valid;
        ovf_n   = overflow;
        gap_n   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (press_c) begin
                    bits_n  = MAX_SYMS'(dash_c);
                    len_n   = LEN_W'(1);
                    gap_n   = '0;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (press_c && (sym_len < LEN_W'(MAX_SYMS))) begin
                    bits_n = sym_bits | (MAX_SYMS'(dash_c) << sym_len);
                    len_n  = sym_len + LEN_W'(1);
                end
                if (!both_rel_c) begin
                    gap_n = '0;
                end else if (gap_cnt < CNT_W'(GAP_CYC)) begin
                    gap_n = gap_cnt + CNT_W'(1);
                end
                if ((gap_cnt == CNT_W'(GAP_CYC)) ||
                    ((sym_len == LEN_W'(MAX_SYMS)) && both_rel_c)) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                end
            end
            HOLD: begin
                if (sym_valid && sym_ready) begin
                    state_n = IDLE;
                    bits_n  = '0;
                    len_n   = '0;
                    gap_n   = '0;
                    ovf_n   = 1'b0;
                    valid_n = 1'b0;
                end else if (press_c) begin
                    ovf_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sym_bits  <= '0;
            sym_len   <= '0;
            sym_valid <= 1'b0;
            overflow  <= 1'b0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            sym_bits  <= bits_n;
            sym_len   <= len_n;
            sym_valid <= valid_n;
            overflow  <= ovf_n;
            gap_cnt   <= gap_n;
            busy      <= (state_n != IDLE);
        end
    end

`ifdef MORSE_LETTER_DECODE_EN
    // International Morse table; element 0 is bit 0, dash = 1.
    function automatic logic [7:0] decode(input logic [MAX_SYMS-1:0] b,
                                          input logic [LEN_W-1:0] l);
        logic [7:0] e;
        logic [7:0] l8;
        logic [7:0] r;
        e  = 8'(b);
        l8 = 8'(l);
        r  = 8'h3F;
        if ((l8 != 8'd0) && (l8 <= 8'd4)) begin
            case ({l8[2:0], e[3:0]})
                {3'd1, 4'b0000}: r = 8'h45; // E
                {3'd1, 4'b0001}: r = 8'h54; // T
                {3'd2, 4'b0010}: r = 8'h41; // A
                {3'd2, 4'b0000}: r = 8'h49; // I
                {3'd2, 4'b0011}: r = 8'h4D; // M
                {3'd2, 4'b0001}: r = 8'h4E; // N
                {3'd3, 4'b0001}: r = 8'h44; // D
                {3'd3, 4'b0011}: r = 8'h47; // G
                {3'd3, 4'b0101}: r = 8'h4B; // K
                {3'd3, 4'b0111}: r = 8'h4F; // O
                {3'd3, 4'b0010}: r = 8'h52; // R
                {3'd3, 4'b0000}: r = 8'h53; // S
                {3'd3, 4'b0100}: r = 8'h55; // U
                {3'd3, 4'b0110}: r = 8'h57; // W
                {3'd4, 4'b0001}: r = 8'h42; // B
                {3'd4, 4'b0101}: r = 8'h43; // C
                {3'd4, 4'b0100}: r = 8'h46; // F
                {3'd4, 4'b0000}: r = 8'h48; // H
                {3'd4, 4'b1110}: r = 8'h4A; // J
                {3'd4, 4'b0010}: r = 8'h4C; // L
                {3'd4, 4'b0110}: r = 8'h50; // P
                {3'd4, 4'b1011}: r = 8'h51; // Q
                {3'd4, 4'b1000}: r = 8'h56; // V
                {3'd4, 4'b1001}: r = 8'h58; // X
                {3'd4, 4'b1101}: r = 8'h59; // Y
                {3'd4, 4'b0011}: r = 8'h5A; // Z
                default:         r = 8'h3F;
            endcase
        end
        return r;
    endfunction

    // Letter is registered alongside sym_valid and is zero while no word is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            letter <= 8'h00;
        end else begin
            letter <= valid_n ? decode(bits_n, len_n) : 8'h00;
        end
    end
`else
    assign letter = 8'h00;
`endif

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Self-checking bench for morse_symbol_capture with short debounce/gap timing.
module tb_morse_symbol_capture;

    localparam int unsigned M  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned G  = 20;
    localparam int unsigned LW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          button1;
    logic          button2;
    logic [M-1:0]  sym_bits;
    logic [LW-1:0] sym_len;
    logic          sym_valid;
    logic          sym_ready;
    logic          overflow;
    logic          busy;
    logic [7:0]    letter;

    typedef struct packed {
        logic [M-1:0]  bits;
        logic [LW-1:0] len;
        logic [7:0]    letter;
    } word_t;

    word_t sb[$];
    int    checks = 0;
    int    errors = 0;

    morse_symbol_capture #(
        .MAX_SYMS(M), .DEBOUNCE_CYC(D), .GAP_CYC(G), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .button1(button1), .button2(button2),
        .sym_bits(sym_bits), .sym_len(sym_len), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .overflow(overflow), .busy(busy), .letter(letter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int which, input int lo, input int hi);
        if (which == 1) button1 = 1'b0;
        else            button2 = 1'b0;
        cyc(lo);
        button1 = 1'b1;
        button2 = 1'b1;
        cyc(hi);
    endtask

    function automatic logic [7:0] exp_letter(input logic [7:0] l);
`ifdef MORSE_LETTER_DECODE_EN
        return l;
`else
        return 8'h00;
`endif
    endfunction

    task automatic push(input logic [M-1:0] b, input logic [LW-1:0] l, input logic [7:0] a);
        word_t w;
        w.bits   = b;
        w.len    = l;
        w.letter = exp_letter(a);
        sb.push_back(w);
    endtask

    task automatic wait_word(input string tag, input int budget);
        int    n;
        word_t e;
        n = 0;
        while (!sym_valid && n < budget) begin
            cyc(1);
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!sym_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_bits"},   32'(sym_bits), 32'(e.bits));
        chk({tag, "_len"},    32'(sym_len),  32'(e.len));
        chk({tag, "_letter"}, 32'(letter),   32'(e.letter));
    endtask

    task automatic handshake();
        sym_ready = 1'b1;
        cyc(1);
        sym_ready = 1'b0;
    endtask

    initial begin
        int saw;
        rst = 1'b1; button1 = 1'b1; button2 = 1'b1; sym_ready = 1'b0;
        cyc(3);
        chk("rst_valid", 32'(sym_valid), 32'd0);
        chk("rst_bits",  32'(sym_bits),  32'd0);
        chk("rst_len",   32'(sym_len),   32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_letter",32'(letter),    32'd0);
        rst = 1'b0;
        cyc(5);

        // Dot, dash, dot closed by the gap timeout -> R.
        push(4'b0010, 3'd3, 8'h52);
        press(1, 8, 8);
        press(2, 8, 8);
        press(1, 8, 0);
        wait_word("r", 80);
        chk("r_busy", 32'(busy), 32'd1);
        handshake();
        chk("r_clr_valid", 32'(sym_valid), 32'd0);
        chk("r_clr_len",   32'(sym_len),   32'd0);
        chk("r_clr_busy",  32'(busy),      32'd0);
        cyc(5);

        // Bouncy dot counts once -> E.
        push(4'b0000, 3'd1, 8'h45);
        button1 = 1'b0; cyc(3);
        button1 = 1'b1; cyc(2);
        press(1, 8, 0);
        wait_word("bounce", 80);
        handshake();
        cyc(5);

        // Short glitch on the idle line records nothing.
        press(1, 3, 40);
        chk("glitch_busy",  32'(busy),      32'd0);
        chk("glitch_valid", 32'(sym_valid), 32'd0);

        // Four dashes close the word at full length without the gap timeout.
        push(4'b1111, 3'd4, 8'h3F);
        press(2, 8, 8);
        press(2, 8, 8);
        press(2, 8, 8);
        press(2, 8, 0);
        wait_word("full", 12);

        // Press while held: overflow, word frozen; transfer clears it.
        press(1, 8, 8);
        chk("hold_ovf",   32'(overflow),  32'd1);
        chk("hold_bits",  32'(sym_bits),  32'hF);
        chk("hold_len",   32'(sym_len),   32'd4);
        chk("hold_valid", 32'(sym_valid), 32'd1);
        handshake();
        chk("xfer_ovf",   32'(overflow),  32'd0);
        chk("xfer_len",   32'(sym_len),   32'd0);
        chk("xfer_valid", 32'(sym_valid), 32'd0);
        chk("xfer_busy",  32'(busy),      32'd0);
        cyc(5);

        // Both keys pressed in the same cycle are ignored.
        button1 = 1'b0; button2 = 1'b0;
        cyc(8);
        button1 = 1'b1; button2 = 1'b1;
        cyc(40);
        chk("both_busy",  32'(busy),      32'd0);
        chk("both_valid", 32'(sym_valid), 32'd0);
        chk("both_len",   32'(sym_len),   32'd0);

        // Reset mid-word discards the partial word.
        press(1, 8, 8);
        press(2, 8, 4);
        chk("mid_busy", 32'(busy),    32'd1);
        chk("mid_len",  32'(sym_len), 32'd2);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (sym_valid) saw = 1;
        end
        chk("rstmid_valid", 32'(saw),     32'd0);
        chk("rstmid_busy",  32'(busy),    32'd0);
        chk("rstmid_len",   32'(sym_len), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
